program_rom: RTL and testbench

PROGRAM_ROM -- requirements
Module: program_rom

---
 rtl/program_rom.sv | 178 +++++++++++++++++
 tb/tb_program_rom.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_rom.sv
// Download memory: a 16-bit loader fills a byte-wide ROM image that the CPU reads through a registered port.
// Define PROGRAM_ROM_CHECKSUM_EN to add a running 16-bit additive checksum of the written bytes.
module program_rom #(
   parameter int ADDR_W     = 12,
   parameter int SWAP_BYTES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_en,
   input  logic              load_wr,
   input  logic [24:0]       load_addr,
   input  logic [15:0]       load_data,
   output logic              load_ready,
   output logic              load_done,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [ADDR_W:0]   loaded_bytes,
   output logic              overflow,
   output logic              drop_err,
   output logic [15:0]       checksum,
   output logic [1:0]        state_dbg
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_FIRST  = 2'd1,
      WR_SECOND = 2'd2
   } state_t;

   // Loader handshake: a word transfers on a cycle where load_en, load_wr and
   // load_ready are all high; load_wr while load_ready is low is dropped and flagged.

   logic [7:0]        mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-2:0] word_q, word_d;
   logic              oor_q, oor_d;
   logic [15:0]       data_q, data_d;
   logic              en_prev_q, en_prev_d;
   logic              done_pend_q, done_pend_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              drop_q, drop_d;
   logic [7:0]        rd_data_q, rd_data_d;

   logic              en_rise, en_fall;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;
   logic              set_ovf, set_drop;
   logic [7:0]        even_byte, odd_byte;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = load_addr[0];

   assign en_rise   = load_en & ~en_prev_q;
   assign en_fall   = ~load_en & en_prev_q;
   assign even_byte = (SWAP_BYTES != 0) ? data_q[15:8] : data_q[7:0];
   assign odd_byte  = (SWAP_BYTES != 0) ? data_q[7:0]  : data_q[15:8];

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      oor_d     = oor_q;
      data_d    = data_q;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      set_ovf   = 1'b0;
      set_drop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_en && load_wr) begin
               word_d  = load_addr[ADDR_W-1:1];
               oor_d   = (load_addr >> ADDR_W) != 25'd0;
               data_d  = load_data;
               state_d = WR_FIRST;
            end
         end
         WR_FIRST: begin
            // Out-of-range words still occupy both write slots so loader timing is fixed.
            if (!oor_q) begin
               mem_we    = 1'b1;
               mem_waddr = {word_q, 1'b0};
               mem_wdata = even_byte;
            end else begin
               set_ovf = 1'b1;
            end
            state_d = WR_SECOND;
         end
         WR_SECOND: begin
            if (!oor_q) begin
               mem_we    = 1'b1;
               mem_waddr = {word_q, 1'b1};
               mem_wdata = odd_byte;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && load_wr) set_drop = 1'b1;
   end

   always_comb begin
      en_prev_d = load_en;
      count_d   = en_rise ? '0 : count_q;
      if (mem_we && count_d != FULL) count_d = count_d + 1'b1;
      ovf_d  = (ovf_q & ~en_rise) | set_ovf;
      drop_d = (drop_q & ~en_rise) | set_drop;
      // A fall seen mid-write is remembered until the FSM gets back to IDLE.
      done_pend_d = done_pend_q;
      if (en_fall) done_pend_d = 1'b1;
      if (state_q == IDLE || en_rise) done_pend_d = 1'b0;
      rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         oor_q       <= 1'b0;
         data_q      <= '0;
         en_prev_q   <= 1'b0;
         done_pend_q <= 1'b0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         drop_q      <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         oor_q       <= oor_d;
         data_q      <= data_d;
         en_prev_q   <= en_prev_d;
         done_pend_q <= done_pend_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Image survives reset; the read above samples the pre-write contents on a collision.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

`ifdef PROGRAM_ROM_CHECKSUM_EN
   logic [15:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = en_rise ? 16'h0000 : cksum_q;
      if (mem_we) cksum_d = cksum_d + {8'h00, mem_wdata};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cksum_q <= 16'h0000;
      else          cksum_q <= cksum_d;
   end

   assign checksum = cksum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign load_ready   = (state_q == IDLE);
   assign load_done    = (state_q == IDLE) && (en_fall || done_pend_q);
   assign rd_data      = rd_data_q;
   assign loaded_bytes = count_q;
   assign overflow     = ovf_q;
   assign drop_err     = drop_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_program_rom.sv
// Bench for program_rom: two instances (byte swap on/off) share stimulus; reads are
// scored against a byte-array model of the downloaded image.
module tb_program_rom;

   localparam int AW    = 12;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_en, load_wr, rd_en;
   logic [24:0] load_addr;
   logic [15:0] load_data;
   logic [AW-1:0] rd_addr;

   logic        load_ready_a, load_done_a, overflow_a, drop_a;
   logic        load_ready_b, load_done_b, overflow_b, drop_b;
   logic [7:0]  rd_data_a, rd_data_b;
   logic [AW:0] loaded_a, loaded_b;
   logic [15:0] checksum_a, checksum_b;
   logic [1:0]  state_a, state_b;

   always #5 clk = ~clk;

   program_rom #(.ADDR_W(AW), .SWAP_BYTES(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_wr(load_wr),
      .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready_a),
      .load_done(load_done_a), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .loaded_bytes(loaded_a), .overflow(overflow_a), .drop_err(drop_a),
      .checksum(checksum_a), .state_dbg(state_a)
   );

   program_rom #(.ADDR_W(AW), .SWAP_BYTES(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_wr(load_wr),
      .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready_b),
      .load_done(load_done_b), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .loaded_bytes(loaded_b), .overflow(overflow_b), .drop_err(drop_b),
      .checksum(checksum_b), .state_dbg(state_b)
   );

   // Reference model of the image as each instance should hold it.
   logic [7:0]  mdl_a [DEPTH];
   logic [7:0]  mdl_b [DEPTH];
   bit          known [DEPTH];
   int          exp_loaded, ck_a, ck_b;
   bit          exp_ovf, exp_drop;
   logic [15:0] exp_q[$];
   int          total, bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status();
      chk("loaded_a", 32'(loaded_a), 32'(exp_loaded));
      chk("loaded_b", 32'(loaded_b), 32'(exp_loaded));
      chk("overflow_a", 32'(overflow_a), 32'(exp_ovf));
      chk("overflow_b", 32'(overflow_b), 32'(exp_ovf));
      chk("drop_err_a", 32'(drop_a), 32'(exp_drop));
      chk("drop_err_b", 32'(drop_b), 32'(exp_drop));
`ifdef PROGRAM_ROM_CHECKSUM_EN
      chk("checksum_a", 32'(checksum_a), 32'(ck_a));
      chk("checksum_b", 32'(checksum_b), 32'(ck_b));
`else
      chk("checksum_a", 32'(checksum_a), 32'h0);
      chk("checksum_b", 32'(checksum_b), 32'h0);
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'({load_ready_a, load_ready_b}), 32'h3);
      chk({tag, "_done"}, 32'({load_done_a, load_done_b}), 32'h0);
      chk({tag, "_rd_data"}, 32'({rd_data_a, rd_data_b}), 32'h0);
      chk({tag, "_loaded"}, 32'({loaded_a, loaded_b}), 32'h0);
      chk({tag, "_flags"}, 32'({overflow_a, overflow_b, drop_a, drop_b}), 32'h0);
      chk({tag, "_checksum"}, 32'({checksum_a, checksum_b}), 32'h0);
   endtask

   // One byte lands in the image: instance a got va, instance b got vb.
   task automatic mdl_byte(input int a, input logic [7:0] va, input logic [7:0] vb);
      mdl_a[a] = va;
      mdl_b[a] = vb;
      known[a] = 1'b1;
      if (exp_loaded < DEPTH) exp_loaded++;
      ck_a = (ck_a + int'(va)) & 32'hFFFF;
      ck_b = (ck_b + int'(vb)) & 32'hFFFF;
   endtask

   task automatic open_window();
      load_en    = 1'b1;
      exp_loaded = 0;
      exp_ovf    = 1'b0;
      exp_drop   = 1'b0;
      ck_a       = 0;
      ck_b       = 0;
      cyc();
      chk_status();
   endtask

   task automatic close_idle();
      load_en = 1'b0;
      #1;
      chk("done_idle_fall", 32'({load_done_a, load_done_b}), 32'h3);
      cyc();
      chk("done_idle_after", 32'({load_done_a, load_done_b}), 32'h0);
   endtask

   task automatic do_read(input int a);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back({mdl_a[a], mdl_b[a]});
      cyc();
      rd_en = 1'b0;
   endtask

   // Issue one 16-bit load. dbl keeps load_wr high one extra cycle, probe reads the
   // even byte in the cycle it is overwritten, rst_mid resets during the odd-byte slot.
   task automatic load_word(input logic [24:0] addr, input logic [15:0] data,
                            input bit dbl, input bit probe, input bit rst_mid);
      int base;
      bit inr;
      base = int'({addr[11:1], 1'b0});
      inr  = (addr < 25'd4096);
      load_wr   = 1'b1;
      load_addr = addr;
      load_data = data;
      cyc();
      chk("ready_slot1", 32'({load_ready_a, load_ready_b}), 32'h0);
      if (dbl) begin
         load_data = ~data;
         exp_drop  = 1'b1;
      end else begin
         load_wr = 1'b0;
      end
      if (probe && inr && known[base]) begin
         rd_en   = 1'b1;
         rd_addr = AW'(base);
         exp_q.push_back({mdl_a[base], mdl_b[base]});
      end
      cyc();
      load_wr = 1'b0;
      rd_en   = 1'b0;
      if (inr) mdl_byte(base, data[15:8], data[7:0]);
      else     exp_ovf = 1'b1;
      chk("ready_slot2", 32'({load_ready_a, load_ready_b}), 32'h0);
      if (rst_mid) begin
         reset_n = 1'b0;
         #1;
         chk_reset_vals("rst_mid");
         exp_loaded = 0;
         exp_ovf    = 1'b0;
         exp_drop   = 1'b0;
         ck_a       = 0;
         ck_b       = 0;
         cyc();
         reset_n = 1'b1;
         cyc();
         chk_status();
      end else begin
         cyc();
         if (inr) mdl_byte(base + 1, data[7:0], data[15:8]);
         chk("ready_back", 32'({load_ready_a, load_ready_b}), 32'h3);
         chk_status();
      end
   endtask

   // Monitor: any cycle the DUT was asked to read, pop and compare; otherwise rd_data must hold.
   initial begin
      bit          p;
      logic [15:0] last, e;
      last = '0;
      forever begin
         @(posedge clk);
         p = rd_en && reset_n;
         @(negedge clk);
         if (!reset_n) begin
            last = '0;
            chk("rd_data_reset", 32'({rd_data_a, rd_data_b}), 32'h0);
         end else if (p) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_unexpected: got %0h expected nothing queued", {rd_data_a, rd_data_b});
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'({rd_data_a, rd_data_b}), 32'(e));
               last = e;
            end
         end else begin
            chk("rd_hold", 32'({rd_data_a, rd_data_b}), 32'(last));
         end
      end
   end

   initial begin
      logic [24:0] ra;
      reset_n = 1'b0;
      load_en = 1'b0; load_wr = 1'b0; load_addr = '0; load_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      total = 0; bad = 0;
      exp_loaded = 0; exp_ovf = 1'b0; exp_drop = 1'b0; ck_a = 0; ck_b = 0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      #12;
      chk_reset_vals("por");
      load_en = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc();

      // Known-answer load and read-back, both byte orders.
      load_word(25'h10, 16'hA55A, 1'b0, 1'b0, 1'b0);
      chk("kat_loaded", 32'(loaded_a), 32'd2);
      do_read(16'h11);
      chk("kat_odd_swap1", 32'(rd_data_a), 32'h5A);
      chk("kat_odd_swap0", 32'(rd_data_b), 32'hA5);
      do_read(16'h10);
      chk("kat_even_swap1", 32'(rd_data_a), 32'hA5);
      chk("kat_even_swap0", 32'(rd_data_b), 32'h5A);

      load_word(25'h0, 16'h0102, 1'b0, 1'b0, 1'b0);
      load_word(25'h20, 16'h1234, 1'b1, 1'b0, 1'b0);
      chk("drop_loaded", 32'(loaded_a), 32'd6);
      load_word(25'h1000, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      do_read(0);
      do_read(1);
      cyc();
      load_word(25'h11, 16'h3C3C, 1'b0, 1'b1, 1'b0);
      do_read(16'h10);

      // load_en falls while the FSM is in WR_FIRST.
      load_wr = 1'b1; load_addr = 25'h30; load_data = 16'h7E81;
      cyc();
      load_wr = 1'b0;
      load_en = 1'b0;
      #1;
      chk("done_wr_first", 32'({load_done_a, load_done_b}), 32'h0);
      cyc();
      mdl_byte(16'h30, 8'h7E, 8'h81);
      chk("done_wr_second", 32'({load_done_a, load_done_b}), 32'h0);
      cyc();
      mdl_byte(16'h31, 8'h81, 8'h7E);
      chk("done_pulse", 32'({load_done_a, load_done_b}), 32'h3);
      cyc();
      chk("done_once", 32'({load_done_a, load_done_b}), 32'h0);
      chk_status();
      do_read(16'h31);

      // New window clears the counters; bytes FF,FF,02,00 sum to 0x0200.
      open_window();
      load_word(25'h40, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      load_word(25'h42, 16'h0200, 1'b0, 1'b0, 1'b0);
`ifdef PROGRAM_ROM_CHECKSUM_EN
      chk("checksum_kat", 32'(checksum_a), 32'h0200);
`endif
      close_idle();

      // Fill the whole image, then two extra words must not move loaded_bytes past the depth.
      open_window();
      for (int w = 0; w < DEPTH / 2; w++)
         load_word(25'(w * 2), 16'($urandom), 1'b0, 1'b0, 1'b0);
      load_word(25'h100, 16'($urandom), 1'b0, 1'b0, 1'b0);
      load_word(25'h102, 16'($urandom), 1'b0, 1'b0, 1'b0);
      chk("loaded_saturated", 32'(loaded_a), 32'd4096);

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 7) == 0) ra = 25'($urandom_range(4096, 33554431));
            else                           ra = 25'($urandom_range(0, 4095));
            load_word(ra, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b0);
         end else begin
            do_read(int'($urandom_range(0, 4095)));
            if ($urandom_range(0, 1) == 1) cyc();
         end
      end

      // Reset in WR_SECOND: immediate reset values, odd byte abandoned, image retained.
      load_word(25'h80, 16'h5A5A, 1'b0, 1'b0, 1'b0);
      do_read(16'h81);
      load_word(25'h80, 16'h1111, 1'b0, 1'b0, 1'b1);
      do_read(16'h80);
      do_read(16'h81);
      chk("rst_odd_kept", 32'(rd_data_a), 32'h5A);
      do_read(16'h10);

      repeat (3) cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
